// File: rtl/demux_pkg.sv
// Shared constants, slot state encoding and helpers for the buffered 1-to-N demux.
package demux_pkg;

  localparam int unsigned DROP_W       = 8;
  localparam int unsigned MAX_CHANNELS = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Saturating increment used by the drop counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with valid/ready handshake; a draining slot reports free.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             free
);

  slot_state_e state;
  slot_state_e state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: begin
        if (load) begin
          state_nxt = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        // A same-cycle load while draining keeps the slot full with new data.
        if (ready && !load) begin
          state_nxt = SLOT_EMPTY;
        end
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    free  = 1'b1;
    if (state == SLOT_FULL) begin
      valid = 1'b1;
      free  = ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux1xn_buf.sv
// Buffered 1-to-N demux: select decode, in_ready mux, drop counter and per-channel slots.
// Optional broadcast input enabled by defining DEMUX1XN_BCAST_EN.
module demux1xn_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
`ifdef DEMUX1XN_BCAST_EN
  input  logic                      in_bcast,
`endif
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [DROP_W-1:0]         drop_cnt
);

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS || WIDTH < 1) begin : g_bad_cfg
    $error("demux1xn_buf: unsupported WIDTH/CHANNELS configuration");
  end

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] sel_onehot;
  logic                sel_hit;
  logic                sel_free;
  logic                bcast;
  logic                xfer;

`ifdef DEMUX1XN_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Decode the select; an out-of-range index hits no channel.
  always_comb begin
    sel_onehot = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_onehot[k] = 1'b1;
      end
    end
    sel_hit  = |sel_onehot;
    sel_free = |(sel_onehot & free);
  end

  always_comb begin
    in_ready = 1'b1;
    if (bcast) begin
      in_ready = &free;
    end else if (sel_hit) begin
      in_ready = sel_free;
    end
  end

  // A handshake during reset is discarded.
  always_comb begin
    xfer = in_valid && in_ready && !rst;
    load = '0;
    if (xfer) begin
      load = bcast ? {CHANNELS{1'b1}} : sel_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (xfer && !bcast && !sel_hit) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .d    (in_data),
      .ready(out_ready[k]),
      .valid(out_valid[k]),
      .q    (out_data[k*WIDTH +: WIDTH]),
      .free (free[k])
    );
  end

endmodule

// File: tb/tb_demux1xn_buf.sv
// Bench for demux1xn_buf: a 4-channel and a 3-channel instance, a slot-level model
// checked every cycle, plus directed literal checks.
module tb_demux1xn_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CHANNELS=4
  logic        rst_a = 1'b1, iv_a = 1'b0, bc_a = 1'b0, ready_a;
  logic [1:0]  sel_a = '0;
  logic [7:0]  d_a = '0, drop_a;
  logic [3:0]  ordy_a = '0, valid_a;
  logic [31:0] data_a;

  // Instance B: CHANNELS=3
  logic        rst_b = 1'b1, iv_b = 1'b0, bc_b = 1'b0, ready_b;
  logic [1:0]  sel_b = '0;
  logic [7:0]  d_b = '0, drop_b;
  logic [2:0]  ordy_b = '0, valid_b;
  logic [23:0] data_b;

  demux1xn_buf #(.WIDTH(8), .CHANNELS(4)) u_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ready_a),
`ifdef DEMUX1XN_BCAST_EN
    .in_bcast(bc_a),
`endif
    .in_sel(sel_a), .in_data(d_a), .out_valid(valid_a), .out_ready(ordy_a),
    .out_data(data_a), .drop_cnt(drop_a)
  );

  demux1xn_buf #(.WIDTH(8), .CHANNELS(3)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(ready_b),
`ifdef DEMUX1XN_BCAST_EN
    .in_bcast(bc_b),
`endif
    .in_sel(sel_b), .in_data(d_b), .out_valid(valid_b), .out_ready(ordy_b),
    .out_data(data_b), .drop_cnt(drop_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: which slots hold a word, their contents, drop count.
  logic [3:0] m_valid [2];
  logic [7:0] m_data  [2][4];
  int         m_drop  [2];
  bit         seen    [2];

  function automatic logic exp_ready(input logic [3:0] mv, input logic [3:0] ordy,
                                     input logic [1:0] sel, input logic bc, input int nc);
    logic [3:0] fr;
    logic       all_free;
    fr = ~mv | ordy;
    all_free = 1'b1;
    for (int k = 0; k < nc; k++) all_free &= fr[k];
    if (bc) return all_free;
    if (int'(sel) < nc) return fr[sel];
    return 1'b1;
  endfunction

  task automatic model_step(input int d, input logic r, input logic iv, input logic [1:0] sel,
                            input logic [7:0] dat, input logic [3:0] ordy, input logic bc);
    int   nc;
    logic rdy;
    nc = (d == 0) ? 4 : 3;
    if (r) begin
      m_valid[d] = '0;
      for (int k = 0; k < 4; k++) m_data[d][k] = '0;
      m_drop[d] = 0;
      seen[d]   = 1'b1;
    end else if (seen[d]) begin
      rdy = exp_ready(m_valid[d], ordy, sel, bc, nc);
      m_valid[d] = m_valid[d] & ~ordy;
      if (iv && rdy) begin
        if (bc) begin
          for (int k = 0; k < nc; k++) begin
            m_valid[d][k] = 1'b1;
            m_data[d][k]  = dat;
          end
        end else if (int'(sel) < nc) begin
          m_valid[d][sel] = 1'b1;
          m_data[d][sel]  = dat;
        end else if (m_drop[d] < 255) begin
          m_drop[d]++;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, iv_a, sel_a, d_a, ordy_a, bc_a);
    model_step(1, rst_b, iv_b, sel_b, d_b, {1'b0, ordy_b}, bc_b);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (seen[0]) begin
      chk("a_in_ready", 32'(ready_a), 32'(exp_ready(m_valid[0], ordy_a, sel_a, bc_a, 4)));
      chk("a_out_valid", 32'(valid_a), 32'(m_valid[0]));
      chk("a_drop_cnt", 32'(drop_a), 32'(m_drop[0]));
      for (int k = 0; k < 4; k++)
        if (m_valid[0][k]) chk("a_out_data", 32'(data_a[k*8 +: 8]), 32'(m_data[0][k]));
    end
    if (seen[1]) begin
      chk("b_in_ready", 32'(ready_b), 32'(exp_ready({1'b0, m_valid[1][2:0]}, {1'b0, ordy_b}, sel_b, bc_b, 3)));
      chk("b_out_valid", 32'(valid_b), 32'(m_valid[1][2:0]));
      chk("b_drop_cnt", 32'(drop_b), 32'(m_drop[1]));
      for (int k = 0; k < 3; k++)
        if (m_valid[1][k]) chk("b_out_data", 32'(data_b[k*8 +: 8]), 32'(m_data[1][k]));
    end
  end

  task automatic seq_a();
    repeat (2) @(negedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(valid_a), 32'h0);
    chk("reset_drop", 32'(drop_a), 32'h0);
    chk("reset_ready", 32'(ready_a), 32'h1);
    chk("reset_data", data_a, 32'h0);

    // Unicast streaming, all consumers ready.
    #1 ordy_a = 4'hF; iv_a = 1'b1; sel_a = 2'd0; d_a = 8'hA0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(valid_a), 32'(4'b1 << (i - 1)));
      chk("stream_data", 32'(data_a[(i-1)*8 +: 8]), 32'(8'hA0 + 8'(i - 1)));
      #1 sel_a = 2'(i); d_a = 8'hA0 + 8'(i);
    end
    @(negedge clk);
    chk("stream_valid3", 32'(valid_a), 32'h8);
    chk("stream_data3", 32'(data_a[31:24]), 32'hA3);
    #1 iv_a = 1'b0;
    @(negedge clk);
    chk("stream_drained", 32'(valid_a), 32'h0);

    // Back-pressure on channel 2.
    #1 ordy_a = 4'b1011; iv_a = 1'b1; sel_a = 2'd2; d_a = 8'h55;
    @(negedge clk);
    chk("bp_first", 32'(data_a[23:16]), 32'h55);
    #1 d_a = 8'h66;
    #1 chk("bp_ready_low", 32'(ready_a), 32'h0);
    @(negedge clk);
    chk("bp_hold", 32'(data_a[23:16]), 32'h55);
    #1 sel_a = 2'd1; d_a = 8'h11;
    @(negedge clk);
    chk("bp_other_ch", 32'(valid_a), 32'b0110);
    chk("bp_other_data", 32'(data_a[15:8]), 32'h11);
    #1 sel_a = 2'd2; d_a = 8'h66; ordy_a = 4'hF;
    #1 chk("bp_release_ready", 32'(ready_a), 32'h1);
    @(negedge clk);
    chk("bp_refill_valid", 32'(valid_a), 32'b0100);
    chk("bp_refill_data", 32'(data_a[23:16]), 32'h66);
    #1 iv_a = 1'b0;
    @(negedge clk);
    chk("bp_empty", 32'(valid_a), 32'h0);

    // Reset with ch0 and ch1 full; the word offered in the reset cycle is lost.
    #1 ordy_a = 4'h0; iv_a = 1'b1; sel_a = 2'd0; d_a = 8'h01;
    @(negedge clk);
    #1 sel_a = 2'd1; d_a = 8'h02;
    @(negedge clk);
    chk("mid_full", 32'(valid_a), 32'b0011);
    #1 rst_a = 1'b1; sel_a = 2'd3; d_a = 8'hEE;
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_a), 32'h0);
    #1 rst_a = 1'b0; iv_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_word", 32'(valid_a), 32'h0);

`ifdef DEMUX1XN_BCAST_EN
    // Broadcast blocked by a stalled full channel, then released.
    #1 ordy_a = 4'b0111; iv_a = 1'b1; sel_a = 2'd3; d_a = 8'h33;
    @(negedge clk);
    #1 bc_a = 1'b1; sel_a = 2'd0; d_a = 8'h7E;
    #1 chk("bc_ready_low", 32'(ready_a), 32'h0);
    @(negedge clk);
    chk("bc_no_change", 32'(valid_a), 32'h8);
    chk("bc_ch3_hold", 32'(data_a[31:24]), 32'h33);
    #1 ordy_a = 4'hF;
    #1 chk("bc_ready_high", 32'(ready_a), 32'h1);
    @(negedge clk);
    chk("bc_all_valid", 32'(valid_a), 32'hF);
    chk("bc_all_data", data_a, 32'h7E7E7E7E);
    #1 iv_a = 1'b0; bc_a = 1'b0;
    @(negedge clk);
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic seq_b();
    repeat (2) @(negedge clk);
    #1 rst_b = 1'b0; iv_b = 1'b1; sel_b = 2'd3; d_b = 8'h00;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 10)  chk("drop_10", 32'(drop_b), 32'd10);
      if (i == 255) chk("drop_255", 32'(drop_b), 32'd255);
      #1 d_b = 8'(i);
    end
    #1 iv_b = 1'b0;
    @(negedge clk);
    chk("drop_sat", 32'(drop_b), 32'd255);
    chk("drop_no_valid", 32'(valid_b), 32'h0);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux1xn_buf.md
# demux1xn_buf

Parametrised, buffered 1-to-N demultiplexer. It is the successor to the combinational 1x2 demux in the basic-gates library. It routes each accepted input word to one of CHANNELS outputs selected by `in_sel`, and each output has a one-entry register slot with valid/ready handshaking. It sits between a single producer and several consumers on the datapath, for example bus fan-out to register-file or I/O ports.

## Interface
- `WIDTH`, default 8, data word width in bits (≥1).
- `CHANNELS`, default 4, number of output channels (2..16; need not be a power of two).
- `SEL_W`, default `$clog2(CHANNELS)`, select width (derived; not to be overridden).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_sel`  in  SEL_W  target channel index.
- `in_data`  in  WIDTH  input word.
- `out_valid`  out  CHANNELS  bit k: slot k holds a word.
- `out_ready`  in  CHANNELS  bit k: consumer k takes the word.
- `out_data`  out  CHANNELS*WIDTH  slot k word at bits [k*WIDTH +: WIDTH].
- `drop_cnt`  out  8  saturating count of words addressed to a non-existent channel.

## Operation
- Input transfer: occurs when `in_valid && in_ready`. Output transfer k: occurs when `out_valid[k] && out_ready[k]`.
- Slot k is "free" when `!out_valid[k] || out_ready[k]`, so a draining slot counts as free.
- Valid select (`in_sel < CHANNELS`):
  - `in_ready` = free(`in_sel`). Combinational from `in_sel`, `out_valid` and `out_ready`; no dependence on `in_valid`.
  - On transfer, slot `in_sel` loads `in_data` and sets `out_valid`.
- Invalid select (`in_sel ≥ CHANNELS`):
  - `in_ready` = 1.
  - The word is discarded and `drop_cnt` increments, saturating at 255.
- Slot state machine, per channel: EMPTY → FULL on load. FULL → EMPTY on output transfer without load. FULL → FULL on output transfer plus same-cycle load, with new data and `out_valid` held high.
- Hold rule: while `out_valid[k]=1` and `out_ready[k]=0`, `out_data[k]` is stable.
- Channels are independent. Back-pressure on one channel never stalls transfers to another.
- Ordering is preserved per channel. There is no ordering guarantee across channels.

## Timing
- Latency: a word accepted at edge n is visible on `out_valid`/`out_data` after edge n, i.e. 1 cycle.
- Throughput: 1 word/cycle per channel when the consumer holds `out_ready` high.
- Reset (edge with `rst=1`):
  - `out_valid`=0, `out_data`=0, `drop_cnt`=0.
  - `in_ready` follows the combinational rule: during and after reset all slots are free.
- Reset mid-operation: buffered words are lost.
- An input transfer in the reset cycle is ignored.
- An input handshake coinciding with the slot's own output handshake is legal and lossless.
- At `drop_cnt`=255, further drops leave it at 255.

## Configuration
- Macro: `DEMUX1XN_BCAST_EN`.
- Defined:
  - Extra input `in_bcast` (1 bit).
  - When `in_bcast=1`, `in_sel` is ignored and `in_ready` = AND of free(k) over all k.
  - On transfer, every slot loads `in_data`.
  - A broadcast never partially completes.
- Undefined: the port `in_bcast` does not exist and only unicast behaviour is present.

## Structure
- Package `demux_pkg`: the `drop_cnt` width constant (8) and the CHANNELS upper-bound constant (16).
- Sub-module `demux_slot`: a one-entry register with valid/ready, parameter `WIDTH`. It has ports `clk`, `rst`, `load`, `d`, `ready`, `valid`, `q` and `free`, and is instantiated CHANNELS times in a generate loop.
- Top level holds the select decode, `in_ready` mux/AND, and drop counter.

## Test plan
- Reset, then idle, with `CHANNELS`=4:
  - `out_valid`=0000, `drop_cnt`=0, `in_ready`=1.
- Unicast streaming, all `out_ready`=1111:
  - Send 0xA0..0xA3 to sel 0..3 on consecutive cycles.
  - Each appears on its channel exactly 1 cycle after acceptance.
- Back-pressure, `out_ready[2]`=0:
  - Write 0x55 to ch2, then 0x66 to ch2: the second write sees `in_ready`=0 and `out_data[2]` stays 0x55.
  - Writes to ch1 still complete.
  - Raise `out_ready[2]`: 0x66 loads in the same cycle 0x55 drains, and `out_valid[2]` stays 1.
- Invalid select, `CHANNELS`=3, `in_sel`=3:
  - 300 accepted words give `drop_cnt`=255 and `out_valid`=000.
- Reset mid-stream:
  - Assert `rst` with ch0 and ch1 full: next cycle `out_valid`=0, and the word offered during reset does not appear.
- `DEMUX1XN_BCAST_EN`:
  - Broadcast 0x7E with ch3 stalled and full: `in_ready`=0 and no slot changes.
  - Release ch3: all four channels show 0x7E one cycle later.
